// File: rtl/vector_mul_pipe_if.sv
// ----------------------------------------------------------------------------
// vector_mul_pipe_if
//   Bundles the operand and result streams of vector_mul_pipe.
//
//   Operand stream (producer -> multiplier)
//     in_valid_i     operand beat valid
//     in_ready_o     multiplier accepts a beat this cycle
//     in_a_i         operand A, WIDTH bits
//     in_b_i         operand B, WIDTH bits
//     in_a_signed_i  1 = A is two's complement, 0 = unsigned
//     in_b_signed_i  1 = B is two's complement, 0 = unsigned
//     in_tag_i       opaque tag carried with the beat
//
//   Result stream (multiplier -> consumer)
//     out_valid_o    result beat valid
//     out_ready_i    consumer accepts the result
//     out_result_o   full 2*WIDTH-bit product
//     out_tag_o      tag of the result beat
//
//   Modports: slave = the multiplier, master = the producer/consumer side.
//   Signal names keep the multiplier's point of view (_i into it, _o out).
// ----------------------------------------------------------------------------
interface vector_mul_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic                 in_valid_i;
   logic                 in_ready_o;
   logic [WIDTH-1:0]     in_a_i;
   logic [WIDTH-1:0]     in_b_i;
   logic                 in_a_signed_i;
   logic                 in_b_signed_i;
   logic [TAG_W-1:0]     in_tag_i;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [2*WIDTH-1:0]   out_result_o;
   logic [TAG_W-1:0]     out_tag_o;

   modport slave (
      input  in_valid_i, in_a_i, in_b_i, in_a_signed_i, in_b_signed_i, in_tag_i,
      output in_ready_o,
      output out_valid_o, out_result_o, out_tag_o,
      input  out_ready_i
   );

   modport master (
      output in_valid_i, in_a_i, in_b_i, in_a_signed_i, in_b_signed_i, in_tag_i,
      input  in_ready_o,
      input  out_valid_o, out_result_o, out_tag_o,
      output out_ready_i
   );
endinterface

// File: rtl/vector_mul_pipe.sv
// ----------------------------------------------------------------------------
// vector_mul_pipe
//   Exact WIDTH x WIDTH -> 2*WIDTH multiplier with per-beat signedness,
//   an elastic LATENCY-stage pipeline with bubble collapsing, a sideband tag
//   travelling with each product, and a synchronous flush.
//
//   Parameters
//     WIDTH    operand width (2..64)
//     LATENCY  pipeline stages from acceptance to output (1..8)
//     TAG_W    tag width (1..16)
//
//   Ports
//     clk_i    sole clock, rising edge
//     rst_ni   asynchronous active-low reset
//     flush_i  synchronous discard of every in-flight beat
//     busy_o   any stage holds a valid beat
//     bus      vector_mul_pipe_if.slave (operand and result streams)
//
//   The product is formed combinationally in front of stage 0; the remaining
//   stages only carry it, so the output is driven straight from the last
//   stage's registers.
// ----------------------------------------------------------------------------
module vector_mul_pipe #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 3,
   parameter int TAG_W   = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   output logic              busy_o,
   vector_mul_pipe_if.slave  bus
);

   localparam int PW = 2 * WIDTH;

   // -------------------------------------------------------------------------
   // Product. Both operands are extended to the full product width (sign or
   // zero according to their flag); the low PW bits of an unsigned PW x PW
   // multiply of those are then the exact mixed-sign product, and the exact
   // product always fits in PW bits.
   // -------------------------------------------------------------------------
   logic          w_a_sign;
   logic          w_b_sign;
   logic [PW-1:0] w_a_ext;
   logic [PW-1:0] w_b_ext;
   logic [PW-1:0] w_prod;

   assign w_a_sign = bus.in_a_signed_i & bus.in_a_i[WIDTH-1];
   assign w_b_sign = bus.in_b_signed_i & bus.in_b_i[WIDTH-1];
   assign w_a_ext  = {{WIDTH{w_a_sign}}, bus.in_a_i};
   assign w_b_ext  = {{WIDTH{w_b_sign}}, bus.in_b_i};
   assign w_prod   = w_a_ext * w_b_ext;

   // -------------------------------------------------------------------------
   // Pipeline stage state
   // -------------------------------------------------------------------------
   logic [LATENCY-1:0] r_valid;
   logic [PW-1:0]      r_prod [LATENCY];
   logic [TAG_W-1:0]   r_tag  [LATENCY];

   // w_load[k]: stage k takes new content (or becomes empty) this cycle.
   // That is true when the consumer is taking the last result, or when some
   // stage at or after k is empty -- the hole lets everything up to it slide
   // forward by one.
   logic [LATENCY-1:0] w_load;
   logic               w_accept;

   always_comb begin : hole_scan
      logic v_hole;
      // NOTE: every variable written in this block gets a value before any
      // conditional use, so no latch is inferred.
      v_hole = bus.out_ready_i;
      w_load = '0;
      for (int k = LATENCY - 1; k >= 0; k--) begin
         v_hole    = v_hole | ~r_valid[k];
         w_load[k] = v_hole;
      end
   end

   // Depends only on stage valids, out_ready_i, flush and reset, never on
   // in_valid_i, so there is no combinational loop through a producer.
   assign bus.in_ready_o = rst_ni & ~flush_i & w_load[0];
   assign w_accept       = bus.in_valid_i & bus.in_ready_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= '0;
         // NOTE: data registers are reset as well because the result and tag
         // outputs come straight from the last stage and must read zero
         // during reset.
         for (int k = 0; k < LATENCY; k++) begin
            r_prod[k] <= '0;
            r_tag[k]  <= '0;
         end
      end else if (flush_i) begin
         // Only the valid bits matter; stale data in empty stages is never
         // presented with out_valid_o high.
         r_valid <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage read the previous
         // stage's old value in the same edge, giving a true shift.
         if (w_load[0]) begin
            r_valid[0] <= w_accept;
            if (w_accept) begin
               r_prod[0] <= w_prod;
               r_tag[0]  <= bus.in_tag_i;
            end
         end
         for (int k = 1; k < LATENCY; k++) begin
            if (w_load[k]) begin
               r_valid[k] <= r_valid[k-1];
               if (r_valid[k-1]) begin
                  r_prod[k] <= r_prod[k-1];
                  r_tag[k]  <= r_tag[k-1];
               end
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.out_valid_o  = r_valid[LATENCY-1];
   assign bus.out_result_o = r_prod[LATENCY-1];
   assign bus.out_tag_o    = r_tag[LATENCY-1];
   assign busy_o           = |r_valid;

endmodule

// File: tb/tb_vector_mul_pipe.sv
// ----------------------------------------------------------------------------
// tb_vector_mul_pipe
//   Drives two instances of vector_mul_pipe: WIDTH=32/LATENCY=3 for the
//   directed scenarios and, together with WIDTH=8/LATENCY=1, for a randomized
//   run scored against an arithmetic reference model and an in-order queue.
// ----------------------------------------------------------------------------
module tb_vector_mul_pipe;

   localparam int TAG_W = 4;
   localparam int L32   = 3;
   localparam int NBEAT = 2000;

   typedef struct packed {
      logic [63:0]      res;
      logic [TAG_W-1:0] tag;
   } exp_t;

   typedef struct {
      logic [31:0]      a;
      logic [31:0]      b;
      bit               as;
      bit               bs;
      logic [TAG_W-1:0] tag;
      logic [63:0]      exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic flush32;
   logic flush8;
   logic busy32;
   logic busy8;

   int n_cmp = 0;
   int n_err = 0;

   vector_mul_pipe_if #(.WIDTH(32), .TAG_W(TAG_W)) bus32 ();
   vector_mul_pipe_if #(.WIDTH(8),  .TAG_W(TAG_W)) bus8 ();

   vector_mul_pipe #(.WIDTH(32), .LATENCY(L32), .TAG_W(TAG_W)) u_dut32 (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .flush_i (flush32),
      .busy_o  (busy32),
      .bus     (bus32.slave)
   );

   vector_mul_pipe #(.WIDTH(8), .LATENCY(1), .TAG_W(TAG_W)) u_dut8 (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .flush_i (flush8),
      .busy_o  (busy8),
      .bus     (bus8.slave)
   );

   always #5 clk = ~clk;

   // Exact product from plain integer arithmetic, reduced to 2*w bits.
   function automatic logic [63:0] model_mul(input logic [63:0] a, input logic [63:0] b,
                                             input bit as, input bit bs, input int w);
      logic signed [129:0] va;
      logic signed [129:0] vb;
      logic signed [129:0] p;
      logic [63:0]         mask;
      va = $signed({66'd0, a});
      vb = $signed({66'd0, b});
      if (as && a[w-1]) va = va - (130'sd1 <<< w);
      if (bs && b[w-1]) vb = vb - (130'sd1 <<< w);
      p    = va * vb;
      mask = (64'd1 << (2 * w)) - 64'd1;
      return p[63:0] & mask;
   endfunction

   task automatic idle_inputs();
      bus32.in_valid_i    = 1'b0;
      bus32.in_a_i        = '0;
      bus32.in_b_i        = '0;
      bus32.in_a_signed_i = 1'b0;
      bus32.in_b_signed_i = 1'b0;
      bus32.in_tag_i      = '0;
      bus32.out_ready_i   = 1'b1;
      bus8.in_valid_i     = 1'b0;
      bus8.in_a_i         = '0;
      bus8.in_b_i         = '0;
      bus8.in_a_signed_i  = 1'b0;
      bus8.in_b_signed_i  = 1'b0;
      bus8.in_tag_i       = '0;
      bus8.out_ready_i    = 1'b1;
      flush32             = 1'b0;
      flush8              = 1'b0;
   endtask

   task automatic drive32(input logic [31:0] a, input logic [31:0] b, input bit as,
                          input bit bs, input logic [TAG_W-1:0] tag);
      bus32.in_a_i        = a;
      bus32.in_b_i        = b;
      bus32.in_a_signed_i = as;
      bus32.in_b_signed_i = bs;
      bus32.in_tag_i      = tag;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      #12;
      n_cmp++; if (bus32.out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus32.out_valid_o); end
      n_cmp++; if (busy32 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy32); end
      n_cmp++; if (bus32.out_result_o !== 64'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", bus32.out_result_o); end
      n_cmp++; if (bus32.out_tag_o !== 4'd0) begin n_err++; $display("FAIL reset_tag: got %h want 0", bus32.out_tag_o); end
      n_cmp++; if (bus32.in_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", bus32.in_ready_o); end
      n_cmp++; if (bus8.out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_out_valid8: got %b want 0", bus8.out_valid_o); end
      n_cmp++; if (bus8.in_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_in_ready8: got %b want 0", bus8.in_ready_o); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++; if (bus32.in_ready_o !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", bus32.in_ready_o); end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_vectors();
      vec_t v [8];
      v[0] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 4'd5, 64'h3FFF_FFFF_0000_0001};
      v[1] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 4'd1, 64'h4000_0000_0000_0000};
      v[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4'd2, 64'h4000_0000_0000_0000};
      v[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd3, 64'hFFFF_FFFF_0000_0001};
      v[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd4, 64'hFFFF_FFFF_0000_0001};
      v[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'd6, 64'h0000_0000_0000_0001};
      v[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd7, 64'hFFFF_FFFE_0000_0001};
      v[7] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 4'd8, 64'hC000_0000_8000_0000};
      bus32.out_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         drive32(v[i].a, v[i].b, v[i].as, v[i].bs, v[i].tag);
         bus32.in_valid_i = 1'b1;
         @(negedge clk);
         n_cmp++; if (bus32.in_ready_o !== 1'b1) begin n_err++; $display("FAIL vec%0d_in_ready: got %b want 1", i, bus32.in_ready_o); end
         @(posedge clk); #1;
         bus32.in_valid_i = 1'b0;
         n_cmp++; if (bus32.out_valid_o !== 1'b0) begin n_err++; $display("FAIL vec%0d_early_valid: got %b want 0", i, bus32.out_valid_o); end
         repeat (L32 - 1) @(posedge clk);
         #1;
         n_cmp++; if (bus32.out_valid_o !== 1'b1) begin n_err++; $display("FAIL vec%0d_valid: got %b want 1", i, bus32.out_valid_o); end
         n_cmp++; if (bus32.out_result_o !== v[i].exp) begin n_err++; $display("FAIL vec%0d_result: got %h want %h", i, bus32.out_result_o, v[i].exp); end
         n_cmp++; if (bus32.out_tag_o !== v[i].tag) begin n_err++; $display("FAIL vec%0d_tag: got %h want %h", i, bus32.out_tag_o, v[i].tag); end
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_backpressure();
      logic [31:0] a [5];
      logic [31:0] b [5];
      bit          as [5];
      bit          bs [5];
      int          idx = 0;
      int          nres = 0;
      int          cycles = 0;
      logic [63:0] held_res;
      logic [3:0]  held_tag;
      logic [63:0] want;
      for (int i = 0; i < 5; i++) begin
         a[i] = $urandom; b[i] = $urandom; as[i] = 1'($urandom); bs[i] = 1'($urandom);
      end
      @(posedge clk); #1;
      bus32.out_ready_i = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         bus32.in_valid_i = (idx < 5);
         if (idx < 5) drive32(a[idx], b[idx], as[idx], bs[idx], 4'(idx));
         @(negedge clk);
         if (bus32.in_valid_i && bus32.in_ready_o) idx++;
      end
      n_cmp++; if (idx !== 3) begin n_err++; $display("FAIL bp_accepted: got %0d want 3", idx); end
      n_cmp++; if (bus32.in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_full: got %b want 0", bus32.in_ready_o); end
      n_cmp++; if (bus32.out_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %b want 1", bus32.out_valid_o); end
      held_res = bus32.out_result_o;
      held_tag = bus32.out_tag_o;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_cmp++; if (bus32.out_result_o !== held_res || bus32.out_tag_o !== held_tag) begin
            n_err++; $display("FAIL bp_stable: got %h/%h want %h/%h", bus32.out_result_o, bus32.out_tag_o, held_res, held_tag);
         end
         n_cmp++; if (bus32.in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_hold: got %b want 0", bus32.in_ready_o); end
      end
      // Release: consume and accept in the same cycle while full.
      @(posedge clk); #1;
      bus32.out_ready_i = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus32.in_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_full_pass_through: got %b want 1", bus32.in_ready_o); end
      for (int c = 0; c < 30 && nres < 5; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            bus32.in_valid_i = (idx < 5);
            if (idx < 5) drive32(a[idx], b[idx], as[idx], bs[idx], 4'(idx));
            @(negedge clk);
         end
         cycles++;
         if (bus32.out_valid_o && bus32.out_ready_i) begin
            want = model_mul(64'(a[nres]), 64'(b[nres]), as[nres], bs[nres], 32);
            n_cmp++; if (bus32.out_result_o !== want || bus32.out_tag_o !== 4'(nres)) begin
               n_err++; $display("FAIL bp_result%0d: got %h/%h want %h/%h", nres, bus32.out_result_o, bus32.out_tag_o, want, 4'(nres));
            end
            nres++;
         end
         if (bus32.in_valid_i && bus32.in_ready_o) idx++;
      end
      n_cmp++; if (nres !== 5) begin n_err++; $display("FAIL bp_result_count: got %0d want 5", nres); end
      n_cmp++; if (cycles !== 5) begin n_err++; $display("FAIL bp_no_bubble: got %0d cycles want 5", cycles); end
      @(posedge clk); #1;
      bus32.in_valid_i = 1'b0;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_flush();
      int          idx = 0;
      bit          found = 1'b0;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] want;
      bus32.out_ready_i = 1'b0;
      for (int c = 0; c < 10 && idx < 3; c++) begin
         @(posedge clk); #1;
         bus32.in_valid_i = 1'b1;
         drive32($urandom, $urandom, 1'b1, 1'b0, 4'(idx + 10));
         @(negedge clk);
         if (bus32.in_ready_o) idx++;
      end
      @(posedge clk); #1;
      flush32 = 1'b1;
      bus32.in_valid_i = 1'b1;
      drive32(32'd3, 32'd3, 1'b0, 1'b0, 4'd15);
      @(negedge clk);
      n_cmp++; if (busy32 !== 1'b1) begin n_err++; $display("FAIL flush_pre_busy: got %b want 1", busy32); end
      n_cmp++; if (bus32.in_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b want 0", bus32.in_ready_o); end
      @(posedge clk); #1;
      flush32 = 1'b0;
      bus32.in_valid_i = 1'b0;
      n_cmp++; if (bus32.out_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", bus32.out_valid_o); end
      n_cmp++; if (busy32 !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", busy32); end
      a = $urandom; b = $urandom;
      want = model_mul(64'(a), 64'(b), 1'b1, 1'b1, 32);
      bus32.out_ready_i = 1'b1;
      bus32.in_valid_i  = 1'b1;
      drive32(a, b, 1'b1, 1'b1, 4'd9);
      @(negedge clk);
      n_cmp++; if (bus32.in_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_next_ready: got %b want 1", bus32.in_ready_o); end
      @(posedge clk); #1;
      bus32.in_valid_i = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (bus32.out_valid_o) begin
            found = 1'b1;
            n_cmp++; if (bus32.out_tag_o !== 4'd9 || bus32.out_result_o !== want) begin
               n_err++; $display("FAIL flush_first_result: got %h/%h want %h/9", bus32.out_result_o, bus32.out_tag_o, want);
            end
         end
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL flush_timeout: got no result want tag 9"); end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset_mid();
      int idx = 0;
      bus32.out_ready_i = 1'b0;
      for (int c = 0; c < 10 && idx < 3; c++) begin
         @(posedge clk); #1;
         bus32.in_valid_i = 1'b1;
         drive32($urandom, $urandom, 1'b0, 1'b1, 4'(idx + 1));
         @(negedge clk);
         if (bus32.in_ready_o) idx++;
      end
      @(posedge clk); #1;
      bus32.in_valid_i = 1'b0;
      n_cmp++; if (bus32.out_valid_o !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_valid: got %b want 1", bus32.out_valid_o); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus32.out_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b want 0", bus32.out_valid_o); end
      n_cmp++; if (busy32 !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy32); end
      n_cmp++; if (bus32.out_result_o !== 64'd0 || bus32.out_tag_o !== 4'd0) begin
         n_err++; $display("FAIL rstmid_data: got %h/%h want 0/0", bus32.out_result_o, bus32.out_tag_o);
      end
      n_cmp++; if (bus32.in_ready_o !== 1'b0) begin n_err++; $display("FAIL rstmid_in_ready: got %b want 0", bus32.in_ready_o); end
      @(negedge clk); #2;
      rst_n = 1'b1;
      bus32.out_ready_i = 1'b1;
      #1;
      n_cmp++; if (bus32.in_ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_release_ready: got %b want 1", bus32.in_ready_o); end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_cmp++; if (bus32.out_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_stale_%0d: got %b want 0", c, bus32.out_valid_o); end
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_random();
      exp_t q32 [$];
      exp_t q8 [$];
      exp_t e;
      exp_t held32;
      exp_t held8;
      bit   hold32 = 1'b0;
      bit   hold8 = 1'b0;
      int   acc32 = 0;
      int   acc8 = 0;
      int   got32 = 0;
      int   got8 = 0;
      for (int c = 0; c < 30000 && (got32 < NBEAT || got8 < NBEAT); c++) begin
         @(posedge clk); #1;
         bus32.in_valid_i    = (acc32 < NBEAT) && ($urandom_range(0, 99) < 70);
         drive32($urandom, $urandom, 1'($urandom), 1'($urandom), 4'($urandom));
         bus32.out_ready_i   = ($urandom_range(0, 99) >= 30);
         bus8.in_valid_i     = (acc8 < NBEAT) && ($urandom_range(0, 99) < 70);
         bus8.in_a_i         = 8'($urandom);
         bus8.in_b_i         = 8'($urandom);
         bus8.in_a_signed_i  = 1'($urandom);
         bus8.in_b_signed_i  = 1'($urandom);
         bus8.in_tag_i       = 4'($urandom);
         bus8.out_ready_i    = ($urandom_range(0, 99) >= 30);
         @(negedge clk);
         // 32-bit / latency-3 instance
         if (hold32) begin
            n_cmp++; if (bus32.out_valid_o !== 1'b1 || bus32.out_result_o !== held32.res || bus32.out_tag_o !== held32.tag) begin
               n_err++; $display("FAIL rnd32_hold: got %b %h/%h want 1 %h/%h", bus32.out_valid_o, bus32.out_result_o, bus32.out_tag_o, held32.res, held32.tag);
            end
         end
         if (bus32.out_valid_o && bus32.out_ready_i) begin
            n_cmp++;
            if (q32.size() == 0) begin
               n_err++; $display("FAIL rnd32_extra: got %h/%h want nothing", bus32.out_result_o, bus32.out_tag_o);
            end else begin
               e = q32.pop_front();
               if (bus32.out_result_o !== e.res || bus32.out_tag_o !== e.tag) begin
                  n_err++; $display("FAIL rnd32_result%0d: got %h/%h want %h/%h", got32, bus32.out_result_o, bus32.out_tag_o, e.res, e.tag);
               end
            end
            got32++;
         end
         hold32 = bus32.out_valid_o && !bus32.out_ready_i;
         held32 = '{res: bus32.out_result_o, tag: bus32.out_tag_o};
         if (bus32.in_valid_i && bus32.in_ready_o) begin
            q32.push_back('{res: model_mul(64'(bus32.in_a_i), 64'(bus32.in_b_i), bus32.in_a_signed_i,
                                           bus32.in_b_signed_i, 32), tag: bus32.in_tag_i});
            acc32++;
         end
         // 8-bit / latency-1 instance
         if (hold8) begin
            n_cmp++; if (bus8.out_valid_o !== 1'b1 || 64'(bus8.out_result_o) !== held8.res || bus8.out_tag_o !== held8.tag) begin
               n_err++; $display("FAIL rnd8_hold: got %b %h/%h want 1 %h/%h", bus8.out_valid_o, bus8.out_result_o, bus8.out_tag_o, held8.res, held8.tag);
            end
         end
         if (bus8.out_valid_o && bus8.out_ready_i) begin
            n_cmp++;
            if (q8.size() == 0) begin
               n_err++; $display("FAIL rnd8_extra: got %h/%h want nothing", bus8.out_result_o, bus8.out_tag_o);
            end else begin
               e = q8.pop_front();
               if (64'(bus8.out_result_o) !== e.res || bus8.out_tag_o !== e.tag) begin
                  n_err++; $display("FAIL rnd8_result%0d: got %h/%h want %h/%h", got8, bus8.out_result_o, bus8.out_tag_o, e.res, e.tag);
               end
            end
            got8++;
         end
         hold8 = bus8.out_valid_o && !bus8.out_ready_i;
         held8 = '{res: 64'(bus8.out_result_o), tag: bus8.out_tag_o};
         if (bus8.in_valid_i && bus8.in_ready_o) begin
            q8.push_back('{res: model_mul(64'(bus8.in_a_i), 64'(bus8.in_b_i), bus8.in_a_signed_i,
                                          bus8.in_b_signed_i, 8), tag: bus8.in_tag_i});
            acc8++;
         end
      end
      n_cmp++; if (got32 !== NBEAT || q32.size() != 0) begin n_err++; $display("FAIL rnd32_count: got %0d (%0d left) want %0d", got32, q32.size(), NBEAT); end
      n_cmp++; if (got8 !== NBEAT || q8.size() != 0) begin n_err++; $display("FAIL rnd8_count: got %0d (%0d left) want %0d", got8, q8.size(), NBEAT); end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   // -------------------------------------------------------------------------
   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vector_mul_pipe.md
VECTOR_MUL_PIPE -- requirements
Module: vector_mul_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits (legal 2..64).
REQ-002 The block SHALL have parameter LATENCY, default 3, pipeline stages from input acceptance to output (legal 1..8).
REQ-003 The block SHALL have parameter TAG_W, default 4, sideband tag width (legal 1..16).
REQ-004 clk_i  input  1  sole clock, all state on rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 in_valid_i  input  1  operand beat valid.
REQ-007 in_ready_o  output  1  block accepts a beat this cycle.
REQ-008 in_a_i  input  WIDTH  operand A.
REQ-009 in_b_i  input  WIDTH  operand B.
REQ-010 in_a_signed_i  input  1  1 = A two's complement, 0 = A unsigned.
REQ-011 in_b_signed_i  input  1  1 = B two's complement, 0 = B unsigned.
REQ-012 in_tag_i  input  TAG_W  opaque tag carried with the beat.
REQ-013 flush_i  input  1  synchronous discard of all in-flight beats.
REQ-014 out_valid_o  output  1  result beat valid.
REQ-015 out_ready_i  input  1  downstream accepts result.
REQ-016 out_result_o  output  2*WIDTH  full-width product.
REQ-017 out_tag_o  output  TAG_W  tag of the result beat.
REQ-018 busy_o  output  1  any stage holds a valid beat.

Function
REQ-019 A beat SHALL be accepted on a rising edge where in_valid_i && in_ready_o && !flush_i.
REQ-020 A result SHALL be consumed on a rising edge where out_valid_o && out_ready_i.
REQ-021 Product SHALL equal exact (2*WIDTH)-bit ext(A)*ext(B), ext = sign-extend when the operand's signed flag is 1, else zero-extend; no truncation or saturation.
REQ-022 Mixed modes SHALL be supported per beat: A signed/B unsigned and A unsigned/B signed give the exact mixed product.
REQ-023 Pipeline SHALL hold LATENCY stages, each with valid bit, product (or partial state) and tag; stage LATENCY-1 drives out_valid_o/out_result_o/out_tag_o directly from registers.
REQ-024 Stages SHALL collapse bubbles: stage k advances into k+1 when k+1 is empty or k+1 itself advances; last stage advances when out_ready_i or empty.
REQ-025 in_ready_o SHALL be 1 when stage 0 is empty or stage 0 advances this cycle; combinational from stage valids and out_ready_i only, never from in_valid_i.
REQ-026 With out_ready_i held 1 and no flush, a beat accepted at edge N SHALL appear with out_valid_o=1 after edge N+LATENCY-1, i.e. visible in cycle following edge N+LATENCY-1, sustaining one result per cycle.
REQ-027 While out_valid_o=1 and out_ready_i=0, out_result_o and out_tag_o SHALL stay stable until consumed.
REQ-028 Results SHALL emerge in acceptance order; tag SHALL travel unchanged with its product.
REQ-029 When all LATENCY stages are full and out_ready_i=0, in_ready_o SHALL be 0; no beat lost or duplicated.
REQ-030 flush_i=1 at an edge SHALL clear all stage valid bits, ignore in_valid_i that cycle, and give out_valid_o=0 next cycle; in_ready_o SHALL be 0 during flush cycle.
REQ-031 Simultaneous consume and accept at full pipeline SHALL proceed with no bubble inserted.
REQ-032 busy_o SHALL be OR of all stage valid bits.
REQ-033 Data/tag registers of empty stages SHALL not affect outputs; out_result_o value with out_valid_o=0 is don't-care.

Reset
REQ-034 rst_ni=0 SHALL immediately (asynchronously) clear all stage valid bits: out_valid_o=0, busy_o=0, out_result_o=0, out_tag_o=0.
REQ-035 During reset in_ready_o SHALL be 0; first acceptance possible at first rising edge after rst_ni deasserts.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight beats; none emerge after release.

Verification
REQ-037 WIDTH=32, LATENCY=3, out_ready=1: A=0x7FFFFFFF, B=0x7FFFFFFF both signed, tag=5 -> after 3 edges out_result=0x3FFFFFFF00000001, tag=5.
REQ-038 Signed A=0x80000000, B=0x80000000 -> 0x4000000000000000; unsigned both -> 0x4000000000000000; A signed 0xFFFFFFFF, B unsigned 0xFFFFFFFF -> 0xFFFFFFFF00000001.
REQ-039 Backpressure: 5 beats back-to-back, out_ready=0 -> exactly 3 accepted, in_ready=0; out_ready=1 -> remaining 2 accepted, 5 results in order, tags 0..4.
REQ-040 Flush with 3 in flight -> next cycle out_valid=0, busy=0; next accepted beat is first result seen.
REQ-041 Assert rst_ni=0 mid-stream between edges -> out_valid_o falls immediately; no stale result after release.
REQ-042 Random: 2000 beats, ~70% valid, ~30% out_ready low, random signed flags, WIDTH in {8,32}, LATENCY in {1,3} -> every result matches reference model, order and count preserved.
